// File: rtl/snake_pkg.sv
// Shared heading encodings and helpers for the Snake button front-end.
// Imported by the conditioner top and its interface users.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;
    localparam logic [1:0] DIR_RESET = DIR_RIGHT;

    // Up<->Down and Left<->Right differ only in bit0.
    function automatic logic [1:0] opposite(input logic [1:0] dir);
        return {dir[1], ~dir[0]};
    endfunction

endpackage

// File: rtl/snake_btn_conditioner_if.sv
// Game-side button bus driven by snake_btn_conditioner (master) and read
// by Snake_Game (slave).
interface snake_btn_conditioner_if;
    logic [3:0] push;
    logic       pause;
    logic [1:0] dir;
    logic       dir_valid;

    modport master (output push, output pause, output dir, output dir_valid);
    modport slave  (input  push, input  pause, input  dir, input  dir_valid);
endinterface

// File: rtl/btn_debounce.sv
// One active-low button: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle press pulse on its debounced falling edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic             deb_q_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, count stable disagreement and commit the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            deb_r   <= 1'b1;
            deb_q_r <= 1'b1;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            deb_q_r <= deb_r;
            if (sync2_r == deb_r) begin
                cnt_r <= '0;
            end else if (cnt_r == LAST_CNT) begin
                deb_r <= sync2_r;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign level = deb_r;
    assign press = deb_q_r & ~deb_r;

endmodule

// File: rtl/snake_btn_conditioner.sv
// Debounces four direction buttons and a pause button, keeps the pause level
// and the accepted heading. Optional macro: SNAKE_BTN_REV_BLOCK_EN.
module snake_btn_conditioner
    import snake_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [3:0]                     i_Btn,
    input  logic                           i_PauseBtn,
    snake_btn_conditioner_if.master        btn
);

    logic [4:0] raw_s;
    logic [4:0] level_s;
    logic [4:0] press_s;
    logic       pause_press_s;
    logic       pause_next_s;
    logic [1:0] win_idx_s;
    logic       rev_block_s;
    logic       accept_s;
    logic       pause_r;
    logic [1:0] dir_r;
    logic       dir_valid_r;

    assign raw_s = {i_PauseBtn, i_Btn};

    for (genvar g = 0; g < 5; g++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (Clk),
            .rst_n (Rst),
            .raw   (raw_s[g]),
            .level (level_s[g]),
            .press (press_s[g])
        );
    end

    assign pause_press_s = press_s[4] & ~level_s[4];

    // Pause toggles first; the winning direction is judged against the new pause level.
    always_comb begin
        pause_next_s = pause_r ^ pause_press_s;
        if (press_s[0]) begin
            win_idx_s = DIR_UP;
        end else if (press_s[1]) begin
            win_idx_s = DIR_DOWN;
        end else if (press_s[2]) begin
            win_idx_s = DIR_LEFT;
        end else begin
            win_idx_s = DIR_RIGHT;
        end
`ifdef SNAKE_BTN_REV_BLOCK_EN
        rev_block_s = (win_idx_s == opposite(dir_r));
`else
        rev_block_s = 1'b0;
`endif
        accept_s = (|press_s[3:0]) & ~pause_next_s & ~rev_block_s;
    end

    // Pause level, heading and the one-cycle reload strobe.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pause_r     <= 1'b0;
            dir_r       <= DIR_RESET;
            dir_valid_r <= 1'b0;
        end else begin
            pause_r     <= pause_next_s;
            dir_valid_r <= accept_s;
            if (accept_s) begin
                dir_r <= win_idx_s;
            end
        end
    end

    assign btn.push      = level_s[3:0];
    assign btn.pause     = pause_r;
    assign btn.dir       = dir_r;
    assign btn.dir_valid = dir_valid_r;

endmodule

// File: tb/tb_snake_btn_conditioner.sv
// Directed self-checking bench for snake_btn_conditioner with DEB_CYCLES=4;
// expectations follow SNAKE_BTN_REV_BLOCK_EN when it is defined.
module tb_snake_btn_conditioner;
    logic       Clk;
    logic       Rst;
    logic [3:0] i_Btn;
    logic       i_PauseBtn;
    int         checks;
    int         failures;
    int         pulse_cnt;
    int         base;

    snake_btn_conditioner_if bus ();

    snake_btn_conditioner #(.DEB_CYCLES(4)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_Btn      (i_Btn),
        .i_PauseBtn (i_PauseBtn),
        .btn        (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    // Counts strobes of the cycle just ending (old value seen at the edge).
    always @(posedge Clk) begin
        if (bus.dir_valid === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic press_btn(input logic [3:0] b, input logic p);
        i_Btn = b;
        i_PauseBtn = p;
        tick(10);
        i_Btn = 4'b1111;
        i_PauseBtn = 1'b1;
        tick(10);
    endtask

    task automatic test_reset;
        Rst = 1'b0;
        i_Btn = 4'b1111;
        i_PauseBtn = 1'b1;
        tick(2);
        checks++; if (bus.push !== 4'b1111) begin failures++; $display("FAIL reset_push got=%b exp=1111", bus.push); end
        checks++; if (bus.pause !== 1'b0) begin failures++; $display("FAIL reset_pause got=%b exp=0", bus.pause); end
        checks++; if (bus.dir !== 2'd3) begin failures++; $display("FAIL reset_dir got=%0d exp=3", bus.dir); end
        checks++; if (bus.dir_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.dir_valid); end
        Rst = 1'b1;
        base = pulse_cnt;
        tick(100);
        checks++; if (bus.push !== 4'b1111) begin failures++; $display("FAIL idle_push got=%b exp=1111", bus.push); end
        checks++; if (bus.dir !== 2'd3) begin failures++; $display("FAIL idle_dir got=%0d exp=3", bus.dir); end
        checks++; if (bus.pause !== 1'b0) begin failures++; $display("FAIL idle_pause got=%b exp=0", bus.pause); end
        checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL idle_pulses got=%0d exp=0", pulse_cnt - base); end
    endtask

    task automatic test_clean_press;
        base = pulse_cnt;
        i_Btn = 4'b1110;
        tick(5);
        checks++; if (bus.push !== 4'b1111) begin failures++; $display("FAIL clean_early got=%b exp=1111", bus.push); end
        tick(1);
        checks++; if (bus.push !== 4'b1110) begin failures++; $display("FAIL clean_push got=%b exp=1110", bus.push); end
        checks++; if (bus.dir_valid !== 1'b0) begin failures++; $display("FAIL clean_valid_early got=%b exp=0", bus.dir_valid); end
        tick(1);
        checks++; if (bus.dir !== 2'd0) begin failures++; $display("FAIL clean_dir got=%0d exp=0", bus.dir); end
        checks++; if (bus.dir_valid !== 1'b1) begin failures++; $display("FAIL clean_valid got=%b exp=1", bus.dir_valid); end
        tick(1);
        checks++; if (bus.dir_valid !== 1'b0) begin failures++; $display("FAIL clean_valid_end got=%b exp=0", bus.dir_valid); end
        tick(10);
        checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL clean_hold_pulses got=%0d exp=1", pulse_cnt - base); end
        i_Btn = 4'b1111;
        tick(10);
        checks++; if (bus.push !== 4'b1111) begin failures++; $display("FAIL clean_release got=%b exp=1111", bus.push); end
        checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL clean_release_pulses got=%0d exp=1", pulse_cnt - base); end
    endtask

    task automatic test_bounce;
        base = pulse_cnt;
        for (int k = 0; k < 5; k++) begin
            i_Btn = 4'b1011;
            tick(3);
            i_Btn = 4'b1111;
            tick(3);
            checks++; if (bus.push !== 4'b1111) begin failures++; $display("FAIL bounce_push_%0d got=%b exp=1111", k, bus.push); end
        end
        tick(4);
        checks++; if (bus.push !== 4'b1111) begin failures++; $display("FAIL bounce_settle got=%b exp=1111", bus.push); end
        checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", pulse_cnt - base); end
        press_btn(4'b1011, 1'b1);
        checks++; if (bus.dir !== 2'd2) begin failures++; $display("FAIL bounce_hold_dir got=%0d exp=2", bus.dir); end
        checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL bounce_hold_pulses got=%0d exp=1", pulse_cnt - base); end
    endtask

    task automatic test_pause;
        press_btn(4'b1110, 1'b1);
        checks++; if (bus.dir !== 2'd0) begin failures++; $display("FAIL pause_setup_dir got=%0d exp=0", bus.dir); end
        press_btn(4'b1111, 1'b0);
        checks++; if (bus.pause !== 1'b1) begin failures++; $display("FAIL pause_on got=%b exp=1", bus.pause); end
        base = pulse_cnt;
        press_btn(4'b0111, 1'b1);
        checks++; if (bus.dir !== 2'd0) begin failures++; $display("FAIL paused_dir got=%0d exp=0", bus.dir); end
        checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL paused_pulses got=%0d exp=0", pulse_cnt - base); end
        press_btn(4'b1111, 1'b0);
        checks++; if (bus.pause !== 1'b0) begin failures++; $display("FAIL pause_off got=%b exp=0", bus.pause); end
        press_btn(4'b0111, 1'b1);
        checks++; if (bus.dir !== 2'd3) begin failures++; $display("FAIL unpaused_dir got=%0d exp=3", bus.dir); end
        checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL unpaused_pulses got=%0d exp=1", pulse_cnt - base); end
    endtask

    task automatic test_reversal_priority;
        base = pulse_cnt;
        press_btn(4'b1011, 1'b1);
`ifdef SNAKE_BTN_REV_BLOCK_EN
        checks++; if (bus.dir !== 2'd3) begin failures++; $display("FAIL reversal_dir got=%0d exp=3", bus.dir); end
        checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL reversal_pulses got=%0d exp=0", pulse_cnt - base); end
`else
        checks++; if (bus.dir !== 2'd2) begin failures++; $display("FAIL reversal_dir got=%0d exp=2", bus.dir); end
        checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL reversal_pulses got=%0d exp=1", pulse_cnt - base); end
`endif
        base = pulse_cnt;
        press_btn(4'b1100, 1'b1);
        checks++; if (bus.dir !== 2'd0) begin failures++; $display("FAIL priority_dir got=%0d exp=0", bus.dir); end
        checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL priority_pulses got=%0d exp=1", pulse_cnt - base); end
    endtask

    task automatic test_same_cycle;
        base = pulse_cnt;
        press_btn(4'b0111, 1'b0);
        checks++; if (bus.pause !== 1'b1) begin failures++; $display("FAIL same_pause got=%b exp=1", bus.pause); end
        checks++; if (bus.dir !== 2'd0) begin failures++; $display("FAIL same_dir got=%0d exp=0", bus.dir); end
        checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL same_pulses got=%0d exp=0", pulse_cnt - base); end
    endtask

    task automatic test_async_reset;
        i_Btn = 4'b1110;
        tick(8);
        checks++; if (bus.push !== 4'b1110) begin failures++; $display("FAIL prereset_push got=%b exp=1110", bus.push); end
        checks++; if (bus.pause !== 1'b1) begin failures++; $display("FAIL prereset_pause got=%b exp=1", bus.pause); end
        i_Btn = 4'b1101;
        tick(3);
        #5 Rst = 1'b0;
        #1;
        checks++; if (bus.push !== 4'b1111) begin failures++; $display("FAIL async_push got=%b exp=1111", bus.push); end
        checks++; if (bus.pause !== 1'b0) begin failures++; $display("FAIL async_pause got=%b exp=0", bus.pause); end
        checks++; if (bus.dir !== 2'd3) begin failures++; $display("FAIL async_dir got=%0d exp=3", bus.dir); end
        checks++; if (bus.dir_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", bus.dir_valid); end
        @(negedge Clk);
        Rst = 1'b1;
        tick(5);
        checks++; if (bus.push !== 4'b1111) begin failures++; $display("FAIL held_early got=%b exp=1111", bus.push); end
        tick(1);
        checks++; if (bus.push !== 4'b1101) begin failures++; $display("FAIL held_push got=%b exp=1101", bus.push); end
        tick(1);
        checks++; if (bus.dir !== 2'd1) begin failures++; $display("FAIL held_dir got=%0d exp=1", bus.dir); end
        checks++; if (bus.dir_valid !== 1'b1) begin failures++; $display("FAIL held_valid got=%b exp=1", bus.dir_valid); end
        i_Btn = 4'b1111;
        tick(10);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        pulse_cnt = 0;
        base = 0;
        Rst = 1'b0;
        i_Btn = 4'b1111;
        i_PauseBtn = 1'b1;
        @(negedge Clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_pause();
        test_reversal_priority();
        test_same_cycle();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snake_btn_conditioner.md
Name: snake_btn_conditioner

Overview:
- Front-end for Snake_Game. Takes raw, bouncing, active-low push buttons (4 direction buttons and 1 pause button).
- Produces clean, game-ready controls:
  - debounced active-low o_Push[3:0], matching Snake_Game i_Push;
  - level o_Pause, toggled on each press;
  - a registered heading o_Dir with a one-cycle o_DirValid strobe on each accepted turn.
- Sits between the board pins and Snake_Game. It is the transmitting end of the game's button interface.

Parameters:
- DEB_CYCLES, 500000, consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz); must be >= 2.
- CNT_W, $clog2(DEB_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  reset, asynchronous, active-low; one clock; Rst=0 forces all state to reset values immediately.
- i_Btn  in  4  raw direction buttons, active-low; bit0=Up, bit1=Down, bit2=Left, bit3=Right.
- i_PauseBtn  in  1  raw pause button, active-low.
- o_Push  out  4  debounced direction buttons, active-low.
- o_Pause  out  1  pause level, 1=paused.
- o_Dir  out  2  current heading: 0=Up, 1=Down, 2=Left, 3=Right.
- o_DirValid  out  1  one-cycle pulse when o_Dir is (re)loaded by an accepted press.

Behaviour:
- Reset values: o_Push=4'b1111, o_Pause=0, o_Dir=2'd3 (Right), o_DirValid=0. Sync flops preset to 1 (released) and counters to 0.
- Synchronizer: 2-flop per input.
- Debounce, per button:
  - The debounced state D starts at 1.
  - Each cycle the sync output S != D, the counter increments; when S == D, the counter clears.
  - When the counter reaches DEB_CYCLES-1 and S != D still holds, D <= S and the counter clears.
  - Net latency: a clean raw edge reaches o_Push DEB_CYCLES+2 cycles later.
  - Any bounce shorter than DEB_CYCLES clears the counter and yields no change.
- Press event: D goes 1->0 (falling edge of the debounced signal), detected against a 1-cycle delayed copy of D.
- Pause:
  - A pause press event toggles o_Pause one cycle after the debounced edge.
  - Release does nothing.
- Direction acceptance, evaluated in the cycle after the press event:
  - Paused (o_Pause=1): direction presses are ignored. o_Dir unchanged, no o_DirValid.
  - Multiple direction press events in the same cycle: lowest bit index wins; the others are discarded, not queued.
  - Reversal block: presses of the opposite of the current o_Dir (Up<->Down, Left<->Right) are rejected, with no pulse.
  - Accepted press: o_Dir <= index and o_DirValid=1 for exactly one cycle. This includes re-pressing the current heading, which re-pulses.
- Pause event and direction event in the same cycle: the pause toggle applies first, and direction is judged against the new o_Pause value.
- Holding a button: one event only, no autorepeat.
- Reset mid-bounce: counters clear, D returns to 1. A button still held after reset is seen as a fresh press after DEB_CYCLES+2 cycles.

Optional Feature:
- Macro: SNAKE_BTN_REV_BLOCK_EN.
- Defined: the reversal block described above is active.
- Undefined: opposite-direction presses are accepted like any other. Everything else is identical.

Decomposition:
- Package snake_pkg holds:
  - direction constants DIR_UP=2'd0, DIR_DOWN=2'd1, DIR_LEFT=2'd2, DIR_RIGHT=2'd3, DIR_RESET=DIR_RIGHT;
  - function opposite(dir), which flips bit0.
- Sub-module btn_debounce: one button; sync + counter + D + press pulse; parameter DEB_CYCLES. Instantiated 5 times.

Test Plan (DEB_CYCLES=4, 20 ns clock):
- Reset then idle: hold i_Btn=4'b1111 for 100 cycles -> o_Push=4'b1111, o_Dir=3, o_DirValid never asserted, o_Pause=0.
- Clean press: i_Btn=4'b1110 held -> o_Push=4'b1110 exactly 6 cycles after the raw edge; next cycle o_Dir=0 with a single o_DirValid pulse; no further pulse while held.
- Bounce rejection: toggle bit2 with low periods of 3 cycles, 5 times -> o_Push unchanged, no o_DirValid. Then hold low 10 cycles -> o_Dir=2 with one pulse.
- Pause gating:
  - press i_PauseBtn -> o_Pause=1;
  - press bit3 -> no pulse, o_Dir unchanged;
  - press pause again -> o_Pause=0;
  - press bit3 -> o_Dir=3 with a pulse.
- Reversal and priority, starting at o_Dir=3:
  - press bit2 -> no pulse with SNAKE_BTN_REV_BLOCK_EN defined; o_Dir=2 with a pulse when it is undefined;
  - press bits0 and 1 in the same cycle -> o_Dir=0 (lowest index wins).
- Async reset mid-operation: drop Rst during a debounce count with o_Pause=1 -> all outputs return to reset values in the same cycle, without waiting for a Clk edge.
